// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: funnels NREQ result buses onto the register file's two write ports
// with round-robin priority, and keeps the per-register busy scoreboard for decode.
module regfile_wb_arbiter #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5,
  parameter int NREQ      = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*REG_IDX_W-1:0]     req_rd,
  input  logic [NREQ*XLEN-1:0]          req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          wen0,
  output logic [REG_IDX_W-1:0]          wreg_id0,
  output logic [XLEN-1:0]               wreg_data0,
  output logic                          wen1,
  output logic [REG_IDX_W-1:0]          wreg_id1,
  output logic [XLEN-1:0]               wreg_data1,
  input  logic                          alloc_en,
  input  logic [REG_IDX_W-1:0]          alloc_rd,
  output logic [(1<<REG_IDX_W)-1:0]     busy
);

  localparam int NREG = 1 << REG_IDX_W;

  logic [1:0]           r_rrPtr;
  logic [REG_IDX_W-1:0] w_rd   [NREQ];
  logic [XLEN-1:0]      w_data [NREQ];
  logic [NREQ-1:0]      w_grant;
  logic                 w_have0;
  logic                 w_have1;
  logic [1:0]           w_slot0;
  logic [1:0]           w_slot1;
  logic [1:0]           w_idx;
  logic [1:0]           w_lastPtr;
  logic [NREG-1:0]      w_clr;
  logic [NREG-1:0]      w_set;
  logic [NREG-1:0]      w_busyNext;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_rd[g]   = req_rd[g*REG_IDX_W +: REG_IDX_W];
    assign w_data[g] = req_data[g*XLEN +: XLEN];
  end

  // A second request to the same nonzero register as slot0 is skipped so the two
  // ports never target one register in the same cycle.
  always_comb begin
    w_grant = '0;
    w_have0 = 1'b0;
    w_have1 = 1'b0;
    w_slot0 = '0;
    w_slot1 = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_rrPtr + 2'(k);
      if (req_valid[w_idx] && !flush) begin
        if (!w_have0) begin
          w_have0        = 1'b1;
          w_slot0        = w_idx;
          w_grant[w_idx] = 1'b1;
        end else if (!w_have1 && ((w_rd[w_idx] != w_rd[w_slot0]) ||
                                  (w_rd[w_idx] == '0) || (w_rd[w_slot0] == '0))) begin
          w_have1        = 1'b1;
          w_slot1        = w_idx;
          w_grant[w_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = rstn ? w_grant : '0;
  assign w_lastPtr = w_have1 ? w_slot1 : w_slot0;

  // A fresh allocation in the same cycle as a writeback belongs to a newer producer, so set wins.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (w_have0) w_clr[w_rd[w_slot0]] = 1'b1;
    if (w_have1) w_clr[w_rd[w_slot1]] = 1'b1;
    if (alloc_en && !flush) w_set[alloc_rd] = 1'b1;
    w_busyNext    = (busy & ~w_clr) | w_set;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen0       <= 1'b0;
      wreg_id0   <= '0;
      wreg_data0 <= '0;
      wen1       <= 1'b0;
      wreg_id1   <= '0;
      wreg_data1 <= '0;
      busy       <= '0;
      r_rrPtr    <= '0;
    end else if (flush) begin
      wen0 <= 1'b0;
      wen1 <= 1'b0;
      busy <= '0;
    end else begin
      wen0 <= w_have0 && (w_rd[w_slot0] != '0);
      wen1 <= w_have1 && (w_rd[w_slot1] != '0);
      if (w_have0) begin
        wreg_id0   <= w_rd[w_slot0];
        wreg_data0 <= w_data[w_slot0];
        r_rrPtr    <= w_lastPtr + 2'd1;
      end
      if (w_have1) begin
        wreg_id1   <= w_rd[w_slot1];
        wreg_data1 <= w_data[w_slot1];
      end
      busy <= w_busyNext;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a hand-derived vector table of grants, with a small port/scoreboard
// model queuing the registered outputs expected one edge later.
module tb_regfile_wb_arbiter;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic [3:0]    req_valid;
  logic [19:0]   req_rd;
  logic [255:0]  req_data;
  logic [3:0]    req_ready;
  logic          wen0;
  logic [4:0]    wreg_id0;
  logic [63:0]   wreg_data0;
  logic          wen1;
  logic [4:0]    wreg_id1;
  logic [63:0]   wreg_data1;
  logic          alloc_en;
  logic [4:0]    alloc_rd;
  logic [31:0]   busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(64), .REG_IDX_W(5), .NREQ(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wen0(wen0), .wreg_id0(wreg_id0), .wreg_data0(wreg_data0),
    .wen1(wen1), .wreg_id1(wreg_id1), .wreg_data1(wreg_data1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  valid;
    logic [19:0] rd;
    logic        allocEn;
    logic [4:0]  allocRd;
    logic        flush;
    logic [3:0]  expReady;
  } vecT;

  typedef struct {
    logic        wen0;
    logic [4:0]  id0;
    logic [63:0] data0;
    logic        wen1;
    logic [4:0]  id1;
    logic [63:0] data1;
    logic [31:0] busy;
  } expT;

  expT expQ[$];
  vecT vecs[19];
  int modelPtr = 0;
  logic [31:0] modelBusy = '0;

  function automatic logic [63:0] reqData(int t, int i);
    return 64'h0123_4567_0000_0000 + 64'(t * 16 + i);
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one vector, checks the combinational grant, predicts the next-edge outputs, then checks them.
  task automatic applyStimulus(vecT v, int t);
    expT e;
    int s0, s1, idx, last;
    logic [31:0] clr, set;
    req_valid = v.valid;
    req_rd    = v.rd;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = reqData(t, i);
    alloc_en  = v.allocEn;
    alloc_rd  = v.allocRd;
    flush     = v.flush;
    #2;
    checkOutput($sformatf("ready[v%0d]", t), 64'(req_ready), 64'(v.expReady));

    s0 = -1;
    s1 = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (modelPtr + k) % 4;
      if (v.expReady[idx]) begin
        if (s0 < 0) s0 = idx;
        else if (s1 < 0) s1 = idx;
      end
    end
    e = '{default: '0};
    clr = '0;
    set = '0;
    if (s0 >= 0) begin
      e.id0   = v.rd[s0*5 +: 5];
      e.data0 = reqData(t, s0);
      e.wen0  = (e.id0 != 5'd0);
      clr[e.id0] = 1'b1;
    end
    if (s1 >= 0) begin
      e.id1   = v.rd[s1*5 +: 5];
      e.data1 = reqData(t, s1);
      e.wen1  = (e.id1 != 5'd0);
      clr[e.id1] = 1'b1;
    end
    if (v.allocEn) set[v.allocRd] = 1'b1;
    if (v.flush) modelBusy = '0;
    else modelBusy = ((modelBusy & ~clr) | set) & ~32'd1;
    e.busy = modelBusy;
    if (s0 >= 0) begin
      last = (s1 >= 0) ? s1 : s0;
      modelPtr = (last + 1) % 4;
    end
    expQ.push_back(e);

    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput($sformatf("wen0[v%0d]", t), 64'(wen0), 64'(e.wen0));
    checkOutput($sformatf("wen1[v%0d]", t), 64'(wen1), 64'(e.wen1));
    checkOutput($sformatf("busy[v%0d]", t), 64'(busy), 64'(e.busy));
    if (e.wen0) begin
      checkOutput($sformatf("id0[v%0d]", t), 64'(wreg_id0), 64'(e.id0));
      checkOutput($sformatf("data0[v%0d]", t), wreg_data0, e.data0);
    end
    if (e.wen1) begin
      checkOutput($sformatf("id1[v%0d]", t), 64'(wreg_id1), 64'(e.id1));
      checkOutput($sformatf("data1[v%0d]", t), wreg_data1, e.data1);
    end
  endtask

  initial begin
    // rd field packs {rd3, rd2, rd1, rd0}; expReady derived by hand from the round-robin pointer.
    vecs[0]  = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd5},  1'b0, 5'd0,  1'b0, 4'b0001};
    vecs[1]  = '{4'b1000, {5'd6,  5'd0,  5'd0,  5'd0},  1'b0, 5'd0,  1'b0, 4'b1000};
    vecs[2]  = '{4'b1111, {5'd4,  5'd3,  5'd2,  5'd1},  1'b0, 5'd0,  1'b0, 4'b0011};
    vecs[3]  = '{4'b1111, {5'd4,  5'd3,  5'd2,  5'd1},  1'b0, 5'd0,  1'b0, 4'b1100};
    vecs[4]  = '{4'b0111, {5'd0,  5'd8,  5'd7,  5'd7},  1'b0, 5'd0,  1'b0, 4'b0101};
    vecs[5]  = '{4'b0010, {5'd0,  5'd0,  5'd7,  5'd0},  1'b0, 5'd0,  1'b0, 4'b0010};
    vecs[6]  = '{4'b0000, {5'd0,  5'd0,  5'd0,  5'd0},  1'b1, 5'd9,  1'b0, 4'b0000};
    vecs[7]  = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd9},  1'b1, 5'd9,  1'b0, 4'b0001};
    vecs[8]  = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd9},  1'b0, 5'd0,  1'b0, 4'b0001};
    vecs[9]  = '{4'b0010, {5'd0,  5'd0,  5'd0,  5'd0},  1'b1, 5'd0,  1'b0, 4'b0010};
    vecs[10] = '{4'b0011, {5'd0,  5'd0,  5'd0,  5'd0},  1'b0, 5'd0,  1'b0, 4'b0011};
    vecs[11] = '{4'b0000, {5'd0,  5'd0,  5'd0,  5'd0},  1'b1, 5'd12, 1'b0, 4'b0000};
    vecs[12] = '{4'b0111, {5'd0,  5'd12, 5'd2,  5'd1},  1'b1, 5'd13, 1'b1, 4'b0000};
    vecs[13] = '{4'b0111, {5'd0,  5'd12, 5'd2,  5'd1},  1'b0, 5'd0,  1'b0, 4'b0101};
    vecs[14] = '{4'b1111, {5'd10, 5'd10, 5'd10, 5'd10}, 1'b0, 5'd0,  1'b0, 4'b0010};
    vecs[15] = '{4'b1101, {5'd10, 5'd10, 5'd0,  5'd10}, 1'b0, 5'd0,  1'b0, 4'b0100};
    vecs[16] = '{4'b1001, {5'd10, 5'd0,  5'd0,  5'd10}, 1'b0, 5'd0,  1'b0, 4'b1000};
    vecs[17] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd10}, 1'b0, 5'd0,  1'b0, 4'b0001};
    vecs[18] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd20}, 1'b1, 5'd20, 1'b0, 4'b0001};

    rstn      = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_rd    = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = '0;
    alloc_en  = 1'b0;
    alloc_rd  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReady", 64'(req_ready), 64'd0);
    checkOutput("resetWen0", 64'(wen0), 64'd0);
    checkOutput("resetWen1", 64'(wen1), 64'd0);
    checkOutput("resetId0", 64'(wreg_id0), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    req_valid = '0;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 19; t++) applyStimulus(vecs[t], t);

    // The last vector left a write to x20 registered and busy[20] set; async reset must drop both without an edge.
    checkOutput("preResetWen0", 64'(wen0), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("asyncResetWen0", 64'(wen0), 64'd0);
    checkOutput("asyncResetBusy", 64'(busy), 64'd0);
    checkOutput("asyncResetReady", 64'(req_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
